// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the five-stage MIPS datapath.
//
// Generates the combinational stall/flush/freeze strobes, the EX-stage
// forwarding selects, and tracks data-memory wait cycles with a sticky
// timeout flag. Two saturating performance counters record stall and flush
// activity.
//
// Ports:
//   Clk, Reset                      clock, asynchronous active-high reset
//   id_Ra, id_Rb, id_UsesRb         ID-stage source registers / Rb used
//   ex_Ra, ex_Rb, ex_Rw             EX-stage register indices
//   ex_RegWr, ex_MemtoReg           EX control bits (both high = load)
//   ex_BranchTaken, ex_Jump         control transfer resolved in EX
//   mem_Rw, mem_RegWr               MEM-stage destination / write enable
//   wr_Rw, wr_RegWr                 WB-stage destination / write enable
//   mem_Busy                        data memory not ready
//   pc_hold, if_id_hold             PC and IF/ID keep their value
//   if_id_flush                     IF/ID loads a nop
//   hazard                          ID/EX loads a bubble
//   pipe_freeze                     all pipeline registers and PC hold
//   ForwardA, ForwardB              00 regfile, 01 MEM result, 10 WB result
//   mem_err                         sticky memory-timeout flag
//   stall_cnt, flush_cnt            saturating performance counters
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  id_Ra,
  input  logic [4:0]  id_Rb,
  input  logic        id_UsesRb,
  input  logic [4:0]  ex_Ra,
  input  logic [4:0]  ex_Rb,
  input  logic [4:0]  ex_Rw,
  input  logic        ex_RegWr,
  input  logic        ex_MemtoReg,
  input  logic        ex_BranchTaken,
  input  logic        ex_Jump,
  input  logic [4:0]  mem_Rw,
  input  logic        mem_RegWr,
  input  logic [4:0]  wr_Rw,
  input  logic        wr_RegWr,
  input  logic        mem_Busy,
  output logic        pc_hold,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        hazard,
  output logic        pipe_freeze,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic        mem_err,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        mem_err_q, mem_err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        load_use;

  assign load_use = ex_RegWr && ex_MemtoReg && (ex_Rw != 5'd0) &&
                    ((ex_Rw == id_Ra) || (id_UsesRb && (ex_Rw == id_Rb)));

  // Priority: memory freeze, then control transfer, then load-use.
  always_comb begin
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    hazard      = 1'b0;
    pipe_freeze = 1'b0;
    ForwardA    = 2'b00;
    ForwardB    = 2'b00;
    if (!Reset) begin
      if (mem_Busy) begin
        pipe_freeze = 1'b1;
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
      end else if (ex_BranchTaken || ex_Jump) begin
        if_id_flush = 1'b1;
        hazard      = 1'b1;
      end else if (load_use) begin
        pc_hold    = 1'b1;
        if_id_hold = 1'b1;
        hazard     = 1'b1;
      end

      if (mem_RegWr && (mem_Rw != 5'd0) && (mem_Rw == ex_Ra))
        ForwardA = 2'b01;
      else if (wr_RegWr && (wr_Rw != 5'd0) && (wr_Rw == ex_Ra))
        ForwardA = 2'b10;

      if (mem_RegWr && (mem_Rw != 5'd0) && (mem_Rw == ex_Rb))
        ForwardB = 2'b01;
      else if (wr_RegWr && (wr_Rw != 5'd0) && (wr_Rw == ex_Rb))
        ForwardB = 2'b10;
    end
  end

  // wait_q is always 0 in RUN, so entering MEM_WAIT starts the count at 1.
  always_comb begin
    state_d   = state_q;
    wait_d    = 8'd0;
    mem_err_d = mem_err_q;
    if (mem_Busy) begin
      state_d = MEM_WAIT;
      wait_d  = (state_q == MEM_WAIT) ? wait_q + 8'd1 : 8'd1;
      if (wait_q == WAIT_LAST)
        mem_err_d = 1'b1;
    end else begin
      state_d = RUN;
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_hold && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (if_id_flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int unsigned TO = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  id_Ra, id_Rb, ex_Ra, ex_Rb, ex_Rw, mem_Rw, wr_Rw;
  logic        id_UsesRb, ex_RegWr, ex_MemtoReg, ex_BranchTaken, ex_Jump;
  logic        mem_RegWr, wr_RegWr, mem_Busy;
  logic        pc_hold, if_id_hold, if_id_flush, hazard, pipe_freeze, mem_err;
  logic [1:0]  ForwardA, ForwardB;
  logic [15:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset),
    .id_Ra(id_Ra), .id_Rb(id_Rb), .id_UsesRb(id_UsesRb),
    .ex_Ra(ex_Ra), .ex_Rb(ex_Rb), .ex_Rw(ex_Rw),
    .ex_RegWr(ex_RegWr), .ex_MemtoReg(ex_MemtoReg),
    .ex_BranchTaken(ex_BranchTaken), .ex_Jump(ex_Jump),
    .mem_Rw(mem_Rw), .mem_RegWr(mem_RegWr),
    .wr_Rw(wr_Rw), .wr_RegWr(wr_RegWr),
    .mem_Busy(mem_Busy),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .hazard(hazard), .pipe_freeze(pipe_freeze),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: integer counters and a run-length of busy cycles.
  int m_stall, m_flush, m_busy_run;
  bit m_err;

  function automatic int fwd_sel(input logic [4:0] src);
    if (mem_RegWr && mem_Rw != 0 && mem_Rw == src) return 1;
    if (wr_RegWr && wr_Rw != 0 && wr_Rw == src) return 2;
    return 0;
  endfunction

  // Expected strobes as {freeze, pc_hold, if_id_hold, flush, hazard}.
  function automatic logic [4:0] exp_strobes();
    bit is_load, match;
    if (Reset) return 5'b0;
    if (mem_Busy) return 5'b11100;
    if (ex_BranchTaken || ex_Jump) return 5'b00011;
    is_load = ex_RegWr && ex_MemtoReg;
    match = (ex_Rw == id_Ra) || (id_UsesRb && ex_Rw == id_Rb);
    if (is_load && ex_Rw != 0 && match) return 5'b01101;
    return 5'b0;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    logic [4:0] s;
    if (Reset) begin
      m_stall = 0; m_flush = 0; m_busy_run = 0; m_err = 0;
    end else begin
      s = exp_strobes();
      if (s[3] && m_stall < 65535) m_stall++;
      if (s[1] && m_flush < 65535) m_flush++;
      if (mem_Busy) begin
        m_busy_run++;
        if (m_busy_run >= int'(TO)) m_err = 1;
      end else begin
        m_busy_run = 0;
      end
    end
  end

  always @(negedge Clk) begin
    logic [4:0] s;
    s = exp_strobes();
    check("pipe_freeze", int'(pipe_freeze), int'(s[4]));
    check("pc_hold",     int'(pc_hold),     int'(s[3]));
    check("if_id_hold",  int'(if_id_hold),  int'(s[2]));
    check("if_id_flush", int'(if_id_flush), int'(s[1]));
    check("hazard",      int'(hazard),      int'(s[0]));
    check("ForwardA", int'(ForwardA), Reset ? 0 : fwd_sel(ex_Ra));
    check("ForwardB", int'(ForwardB), Reset ? 0 : fwd_sel(ex_Rb));
    check("mem_err",   int'(mem_err),   int'(m_err));
    check("stall_cnt", int'(stall_cnt), m_stall);
    check("flush_cnt", int'(flush_cnt), m_flush);
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    id_Ra = 0; id_Rb = 0; id_UsesRb = 0;
    ex_Ra = 0; ex_Rb = 0; ex_Rw = 0;
    ex_RegWr = 0; ex_MemtoReg = 0; ex_BranchTaken = 0; ex_Jump = 0;
    mem_Rw = 0; mem_RegWr = 0; wr_Rw = 0; wr_RegWr = 0; mem_Busy = 0;
  endtask

  task automatic load_in_ex(input logic [4:0] rw);
    ex_Rw = rw; ex_RegWr = 1; ex_MemtoReg = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    Reset = 1;
    // Drive something that would otherwise stall/forward: reset must mask it.
    mem_Busy = 1; mem_Rw = 7; mem_RegWr = 1; ex_Ra = 7;
    step(2);
    check("reset_pc_hold", int'(pc_hold), 0);
    check("reset_fwdA", int'(ForwardA), 0);
    idle();
    Reset = 0;
    step();
    check("reset_stall_cnt", int'(stall_cnt), 0);

    // Load-use on Ra: one stall cycle, then bubble clears it.
    load_in_ex(5); id_Ra = 5;
    #1 check("lu_hazard", int'(hazard), 1);
    step();
    idle(); id_Ra = 5;
    step();
    check("lu_stall_cnt", int'(stall_cnt), 1);
    check("lu_cleared", int'(pc_hold), 0);

    // Load to r0 never stalls.
    load_in_ex(0); id_Ra = 0; id_Rb = 0; id_UsesRb = 1;
    #1 check("r0_no_stall", int'(pc_hold), 0);
    step();

    // Rb match ignored when Rb not used, honoured when it is.
    idle(); load_in_ex(9); id_Ra = 3; id_Rb = 9; id_UsesRb = 0;
    #1 check("rb_unused", int'(hazard), 0);
    step();
    id_UsesRb = 1;
    #1 check("rb_used", int'(hazard), 1);
    step();

    // Forwarding priority: MEM over WB; r0 never forwarded.
    idle(); ex_Ra = 7; ex_Rb = 7; mem_Rw = 7; wr_Rw = 7; mem_RegWr = 1; wr_RegWr = 1;
    #1 check("fwdA_mem", int'(ForwardA), 1);
    step();
    mem_RegWr = 0;
    #1 check("fwdA_wb", int'(ForwardA), 2);
    step();
    ex_Ra = 0; ex_Rb = 3; mem_Rw = 0; wr_Rw = 3; mem_RegWr = 1;
    step();
    ex_Rb = 12; mem_Rw = 12; wr_Rw = 12;
    step();

    // Branch with simultaneous load-use match: branch wins.
    idle(); load_in_ex(5); id_Ra = 5; ex_BranchTaken = 1;
    #1 check("br_pc_hold", int'(pc_hold), 0);
    step();
    check("br_flush_cnt", int'(flush_cnt), 1);
    ex_BranchTaken = 0; ex_Jump = 1;
    step();
    check("jmp_flush_cnt", int'(flush_cnt), 2);

    // Branch during a 3-cycle busy: freeze wins, branch applied afterwards.
    idle(); ex_BranchTaken = 1; mem_Busy = 1;
    step(3);
    check("busy3_err", int'(mem_err), 0);
    mem_Busy = 0;
    #1 check("after_busy_flush", int'(if_id_flush), 1);
    step();
    idle();
    step();

    // Four busy cycles trip the timeout; flag is sticky until reset.
    mem_Busy = 1;
    step(3);
    check("busy_before_to", int'(mem_err), 0);
    step();
    check("busy_to_err", int'(mem_err), 1);
    mem_Busy = 0;
    step(2);
    check("err_sticky", int'(mem_err), 1);
    Reset = 1;
    #1 check("err_async_clr", int'(mem_err), 0);
    step();
    Reset = 0;
    step();

    // Reset mid-wait restarts the busy count.
    mem_Busy = 1;
    step(2);
    #2 Reset = 1;
    #2 Reset = 0;
    step(3);
    check("midwait_no_err", int'(mem_err), 0);
    step();
    check("midwait_err", int'(mem_err), 1);
    idle();
    Reset = 1;
    step();
    Reset = 0;
    step();

    // Stall counter saturation.
    load_in_ex(4); id_Ra = 4;
    step(70000);
    check("stall_sat", int'(stall_cnt), 32'hFFFF);
    idle();
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS datapath. It generates the `hazard` bubble strobe that squashes an instruction entering the ID/EX register, plus the hold, flush and freeze strobes for the PC and the other pipeline registers. It also produces EX-stage forwarding selects and runs a memory-wait state machine with a timeout. It sits beside the pipeline registers and is driven by register indices and control bits tapped from ID, EX, MEM and WB.

## Interface
- `MEM_TIMEOUT`, default 64: consecutive `mem_Busy` cycles that set `mem_err`; legal range 2..255.
- `Clk`  in  1  pipeline clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `id_Ra`, `id_Rb`  in  5 each  source registers of the instruction in ID.
- `id_UsesRb`  in  1  ID instruction reads Rb (R-type, sw, beq).
- `ex_Ra`, `ex_Rb`, `ex_Rw`  in  5 each  EX-stage register indices.
- `ex_RegWr`, `ex_MemtoReg`  in  1 each  EX-stage control bits; both high means a load.
- `ex_BranchTaken`, `ex_Jump`  in  1 each  control transfer resolved in EX.
- `mem_Rw`  in  5; `mem_RegWr`  in  1  MEM-stage destination register and write enable.
- `wr_Rw`  in  5; `wr_RegWr`  in  1  WB-stage destination register and write enable.
- `mem_Busy`  in  1  data memory not ready this cycle.
- `pc_hold`, `if_id_hold`  out  1 each  PC and IF/ID keep their value.
- `if_id_flush`  out  1  IF/ID loads a nop.
- `hazard`  out  1  ID/EX loads a bubble (all control bits cleared).
- `pipe_freeze`  out  1  every pipeline register and the PC hold their value.
- `ForwardA`, `ForwardB`  out  2 each  EX operand select: 00 register file, 01 MEM result, 10 WB result.
- `mem_err`  out  1  sticky memory-timeout flag.
- `stall_cnt`, `flush_cnt`  out  16 each  saturating performance counters.

## Operation
- FSM states: RUN and MEM_WAIT. Reset puts the FSM in RUN.
- Combinational strobes are evaluated in priority order; the first matching rule wins and every other strobe is 0.
  1. `mem_Busy`=1 (any state): `pipe_freeze`=1, `pc_hold`=1, `if_id_hold`=1, `hazard`=0, `if_id_flush`=0.
  2. `ex_BranchTaken` or `ex_Jump` = 1: `if_id_flush`=1, `hazard`=1. `pc_hold`=0 so the PC takes the target. This rule overrides load-use because the ID instruction is on the wrong path.
  3. Load-use: `ex_RegWr` & `ex_MemtoReg` & `ex_Rw`!=0 & (`ex_Rw`==`id_Ra` | (`id_UsesRb` & `ex_Rw`==`id_Rb`)). Response: `pc_hold`=1, `if_id_hold`=1, `hazard`=1 for exactly one cycle. The bubble then occupies EX, so the condition clears without extra state.
- Forwarding (combinational, independent of the rules above):
  - `ForwardA`=01 if `mem_RegWr` & `mem_Rw`!=0 & `mem_Rw`==`ex_Ra`.
  - Otherwise `ForwardA`=10 if `wr_RegWr` & `wr_Rw`!=0 & `wr_Rw`==`ex_Ra`.
  - Otherwise `ForwardA`=00.
  - `ForwardB` uses the same rules with `ex_Rb`. MEM always has priority over WB.
- FSM transitions:
  - RUN to MEM_WAIT when `mem_Busy`=1.
  - MEM_WAIT to RUN when `mem_Busy`=0.
- `wait_cnt` (8 bits, internal):
  - increments every cycle in which `mem_Busy`=1;
  - clears to 0 on any cycle with `mem_Busy`=0.
- `mem_err`:
  - set on the edge where `mem_Busy`=1 and `wait_cnt`==`MEM_TIMEOUT`-1, i.e. the `MEM_TIMEOUT`-th consecutive busy cycle;
  - cleared only by `Reset`;
  - does not alter the strobes, so the freeze continues while busy.
- `stall_cnt` increments on every edge with `pc_hold`=1. `flush_cnt` increments on every edge with `if_id_flush`=1. Both saturate at 16'hFFFF.
- While `Reset`=1, all strobes and selects are forced to 0.

## Timing
- Strobes and forwarding selects are combinational, with zero latency from their inputs within the same cycle. Consumers sample them on the same rising edge.
- Reset values: state RUN, `wait_cnt` 0, `mem_err` 0, `stall_cnt` 0, `flush_cnt` 0.
- Reset asserted mid-wait: state returns to RUN and `mem_err` clears immediately, asynchronously.
- Load-use stall costs one cycle. A taken branch costs two wrong-path slots: the IF/ID flush and the ID/EX bubble.
- A branch and `mem_Busy` in the same cycle: the freeze wins. The branch rule is applied on the first non-busy cycle, since EX inputs are frozen and the branch is still held in EX.

## Test plan
- Load-use: lw into r5 in EX (`ex_Rw`=5, `ex_RegWr`=1, `ex_MemtoReg`=1), `id_Ra`=5 → one cycle of `pc_hold`=`if_id_hold`=`hazard`=1; next cycle all 0; `stall_cnt`=1.
- Load to r0: `ex_Rw`=0 with `id_Ra`=0 → no stall.
- Load-use on Rb with `id_UsesRb`=0 → no stall.
- Forwarding priority: `mem_Rw`=`wr_Rw`=`ex_Ra`=7, both write enables high → `ForwardA`=01. Drop `mem_RegWr` → `ForwardA`=10.
- Branch with a simultaneous load-use match: `ex_BranchTaken`=1 → `if_id_flush`=1, `hazard`=1, `pc_hold`=0; `flush_cnt`=1.
- Memory wait and timeout (`MEM_TIMEOUT`=4):
  - `mem_Busy` held for 3 cycles → `pipe_freeze` high for those 3 cycles, back to RUN, `mem_err`=0.
  - `mem_Busy` held for 4 cycles → `mem_err`=1 after the 4th edge, still 1 after `mem_Busy` drops; `Reset` pulse clears it.
- Counter saturation: force 70000 stall cycles → `stall_cnt`=16'hFFFF.
